// File: rtl/async_fifo_pkt.sv
// Dual-clock FWFT FIFO with valid/ready on both sides, tlast sideband, per-domain
// occupancy counts and watermark flags, and an optional packet-commit mode.
module async_fifo_pkt #(
   parameter int ADDR_WIDTH    = 2,
   parameter int DATA_WIDTH    = 128,
   parameter int SYNC_STAGES   = 2,
   parameter int PACKET_MODE   = 0,
   parameter int AFULL_MARGIN  = 1,
   parameter int AEMPTY_THRESH = 1
) (
   input  logic                  w_clk,
   input  logic                  w_reset,
   input  logic                  r_clk,
   input  logic                  r_reset,
   input  logic                  write_tvalid,
   output logic                  write_tready,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  write_tlast,
   output logic [ADDR_WIDTH:0]   write_count,
   output logic                  write_afull,
   output logic                  read_tvalid,
   input  logic                  read_tready,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic                  read_tlast,
   output logic [ADDR_WIDTH:0]   read_count,
   output logic                  read_aempty
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [PW-1:0] DEPTH_V = PW'(1) << ADDR_WIDTH;

   function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   logic [DATA_WIDTH:0] mem [DEPTH];

   // write domain
   logic [PW-1:0] wptr_bin;
   logic [PW-1:0] wptr_next;
   logic [PW-1:0] cptr_bin;
   logic [PW-1:0] cptr_next;
   logic [PW-1:0] cptr_gray;
   logic [PW-1:0] rptr_gray_sync [SYNC_STAGES];
   logic [PW-1:0] rptr_sync_bin;
   logic [PW-1:0] wcount_next;
   logic [PW-1:0] wfree_next;
   logic          full;
   logic          push;

   // read domain
   logic [PW-1:0] rptr_bin;
   logic [PW-1:0] rptr_next;
   logic [PW-1:0] rptr_gray;
   logic [PW-1:0] cptr_gray_sync [SYNC_STAGES];
   logic [PW-1:0] cptr_sync_bin;
   logic [PW-1:0] rcount_next;
   logic          empty;
   logic          pop;

   assign rptr_sync_bin = gray2bin(rptr_gray_sync[SYNC_STAGES-1]);
   assign full          = (wptr_bin ^ rptr_sync_bin) == DEPTH_V;
   assign write_tready  = !full && !w_reset;
   assign push          = write_tvalid && write_tready;
   assign wptr_next     = wptr_bin + PW'(push);
   assign wcount_next   = wptr_next - rptr_sync_bin;
   assign wfree_next    = DEPTH_V - wcount_next;

   // Only the commit pointer crosses; in streaming mode it simply tracks wptr.
   always_comb begin
      cptr_next = cptr_bin;
      if (PACKET_MODE == 0) cptr_next = wptr_next;
      else if (push && write_tlast) cptr_next = wptr_next;
   end

   always_ff @(posedge w_clk) begin
      if (w_reset) begin
         wptr_bin    <= '0;
         cptr_bin    <= '0;
         cptr_gray   <= '0;
         write_count <= '0;
         write_afull <= 1'b0;
         for (int i = 0; i < SYNC_STAGES; i++) rptr_gray_sync[i] <= '0;
      end else begin
         wptr_bin          <= wptr_next;
         cptr_bin          <= cptr_next;
         cptr_gray         <= bin2gray(cptr_next);
         rptr_gray_sync[0] <= rptr_gray;
         for (int i = 1; i < SYNC_STAGES; i++) rptr_gray_sync[i] <= rptr_gray_sync[i-1];
         write_count       <= wcount_next;
         write_afull       <= (wfree_next <= PW'(AFULL_MARGIN));
      end
   end

   always_ff @(posedge w_clk) begin
      if (push) mem[wptr_bin[ADDR_WIDTH-1:0]] <= {write_tlast, write_data};
   end

   assign cptr_sync_bin = gray2bin(cptr_gray_sync[SYNC_STAGES-1]);
   assign empty         = rptr_bin == cptr_sync_bin;
   assign read_tvalid   = !empty && !r_reset;
   assign pop           = read_tvalid && read_tready;
   assign rptr_next     = rptr_bin + PW'(pop);
   assign rcount_next   = cptr_sync_bin - rptr_next;

   always_ff @(posedge r_clk) begin
      if (r_reset) begin
         rptr_bin    <= '0;
         rptr_gray   <= '0;
         read_count  <= '0;
         read_aempty <= 1'b1;
         for (int i = 0; i < SYNC_STAGES; i++) cptr_gray_sync[i] <= '0;
      end else begin
         rptr_bin          <= rptr_next;
         rptr_gray         <= bin2gray(rptr_next);
         cptr_gray_sync[0] <= cptr_gray;
         for (int i = 1; i < SYNC_STAGES; i++) cptr_gray_sync[i] <= cptr_gray_sync[i-1];
         read_count        <= rcount_next;
         read_aempty       <= (rcount_next <= PW'(AEMPTY_THRESH));
      end
   end

   assign {read_tlast, read_data} = mem[rptr_bin[ADDR_WIDTH-1:0]];

endmodule

// File: tb/tb_async_fifo_pkt.sv
// Bench for async_fifo_pkt: a streaming and a packet-mode instance share stimulus,
// each scenario checks its own instance against a queue-based reference model.
`timescale 1ns/1ps
module tb_async_fifo_pkt;

   localparam int AW = 2;
   localparam int DW = 128;
   localparam int SS = 2;

   logic w_clk = 0, r_clk = 0;
   logic w_reset = 1, r_reset = 1;
   int   w_half = 10, r_half = 5;

   logic          write_tvalid = 0, write_tlast = 0, read_tready = 0;
   logic [DW-1:0] write_data = '0;

   logic          s_write_tready, s_write_afull, s_read_tvalid, s_read_tlast, s_read_aempty;
   logic [AW:0]   s_write_count, s_read_count;
   logic [DW-1:0] s_read_data;
   logic          p_write_tready, p_write_afull, p_read_tvalid, p_read_tlast, p_read_aempty;
   logic [AW:0]   p_write_count, p_read_count;
   logic [DW-1:0] p_read_data;

   int checks = 0;
   int failures = 0;

   // Reference model: accepted beats in order; 'committed' = beats the reader may see.
   logic [DW:0] sb_q[$];
   int committed = 0;

   always begin #(w_half); w_clk = ~w_clk; end
   always begin #(r_half); r_clk = ~r_clk; end

   async_fifo_pkt #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SYNC_STAGES(SS), .PACKET_MODE(0),
                    .AFULL_MARGIN(1), .AEMPTY_THRESH(1)) u_stream (
      .w_clk(w_clk), .w_reset(w_reset), .r_clk(r_clk), .r_reset(r_reset),
      .write_tvalid(write_tvalid), .write_tready(s_write_tready), .write_data(write_data),
      .write_tlast(write_tlast), .write_count(s_write_count), .write_afull(s_write_afull),
      .read_tvalid(s_read_tvalid), .read_tready(read_tready), .read_data(s_read_data),
      .read_tlast(s_read_tlast), .read_count(s_read_count), .read_aempty(s_read_aempty));

   async_fifo_pkt #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SYNC_STAGES(SS), .PACKET_MODE(1),
                    .AFULL_MARGIN(1), .AEMPTY_THRESH(1)) u_packet (
      .w_clk(w_clk), .w_reset(w_reset), .r_clk(r_clk), .r_reset(r_reset),
      .write_tvalid(write_tvalid), .write_tready(p_write_tready), .write_data(write_data),
      .write_tlast(write_tlast), .write_count(p_write_count), .write_afull(p_write_afull),
      .read_tvalid(p_read_tvalid), .read_tready(read_tready), .read_data(p_read_data),
      .read_tlast(p_read_tlast), .read_count(p_read_count), .read_aempty(p_read_aempty));

   function automatic logic [DW-1:0] rand_data();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic do_reset();
      w_reset = 1; r_reset = 1; write_tvalid = 0; read_tready = 0;
      repeat (SS + 4) @(negedge w_clk);
      repeat (SS + 4) @(negedge r_clk);
      w_reset = 0; r_reset = 0;
      sb_q.delete(); committed = 0;
      repeat (2) @(negedge w_clk);
      repeat (2) @(negedge r_clk);
   endtask

   // Constant-valid writer: n beats, tlast only on the final one if last_tl.
   task automatic push_beats(input int n, input bit pkt, input bit last_tl);
      int sent = 0, guard = 0;
      bit acc = 0;
      logic [DW-1:0] d;
      logic tl;
      d = rand_data();
      tl = (n == 1) ? last_tl : 1'b0;
      while (sent < n && guard < 200) begin
         @(negedge w_clk); guard++;
         if (acc) begin
            sb_q.push_back({tl, d});
            if (!pkt || tl) committed = sb_q.size();
            sent++;
            d = rand_data();
            tl = (sent == n - 1) ? last_tl : 1'b0;
         end
         if (sent < n) begin
            write_tvalid = 1; write_data = d; write_tlast = tl;
            acc = pkt ? p_write_tready : s_write_tready;
         end
      end
      write_tvalid = 0;
      checks++;
      if (sent != n) begin failures++; $display("FAIL push_beats sent=%0d expected=%0d", sent, n); end
   endtask

   // Random writer; in packet mode packets are 1..DEPTH beats so the FIFO cannot deadlock.
   task automatic drive_writes(input int n, input bit pkt);
      int sent = 0, guard = 0, pos = 0, len;
      bit acc = 0;
      logic [DW-1:0] d;
      logic tl;
      len = $urandom_range(1, 1 << AW);
      d = rand_data();
      tl = pkt ? ((pos == len - 1) || (n == 1)) : ($urandom_range(0, 1) == 1);
      while (sent < n && guard < 6 * n + 1000) begin
         @(negedge w_clk); guard++;
         if (acc) begin
            sb_q.push_back({tl, d});
            if (!pkt || tl) committed = sb_q.size();
            sent++;
            if (tl) begin pos = 0; len = $urandom_range(1, 1 << AW); end
            else pos++;
            d = rand_data();
            tl = pkt ? ((pos == len - 1) || (sent == n - 1)) : ($urandom_range(0, 1) == 1);
         end
         if (sent < n) begin
            write_tvalid = ($urandom_range(0, 3) != 0);
            write_data = d; write_tlast = tl;
            acc = write_tvalid && (pkt ? p_write_tready : s_write_tready);
         end
      end
      write_tvalid = 0;
      checks++;
      if (sent != n) begin failures++; $display("FAIL write_timeout sent=%0d expected=%0d", sent, n); end
   endtask

   task automatic consume_reads(input int n, input bit pkt, input int rdy_pct);
      int got = 0, guard = 0;
      bit tv, held = 0;
      logic [DW:0] act, held_val, exp;
      while (got < n && guard < 8 * n + 2000) begin
         @(negedge r_clk); guard++;
         tv  = pkt ? p_read_tvalid : s_read_tvalid;
         act = pkt ? {p_read_tlast, p_read_data} : {s_read_tlast, s_read_data};
         if (held) begin
            checks++;
            if (!tv || act !== held_val) begin
               failures++;
               $display("FAIL hold_stable valid=%0b got=%h expected=%h", tv, act, held_val);
            end
            held = 0;
         end
         read_tready = ($urandom_range(0, 99) < rdy_pct);
         if (tv) begin
            checks++;
            if (committed == 0) begin
               failures++;
               $display("FAIL early_visible got=%h expected no valid beat (queued=%0d)", act, sb_q.size());
            end else if (read_tready) begin
               exp = sb_q.pop_front(); committed--; got++;
               checks++;
               if (act !== exp) begin failures++; $display("FAIL read_data beat=%0d got=%h expected=%h", got, act, exp); end
            end else begin
               held = 1; held_val = act;
            end
         end
      end
      read_tready = 0;
      checks++;
      if (got != n) begin failures++; $display("FAIL read_timeout got=%0d expected=%0d", got, n); end
   endtask

   task automatic test_reset();
      w_reset = 1; r_reset = 1; read_tready = 0;
      write_tvalid = 1; write_data = rand_data(); write_tlast = 1;
      repeat (SS + 4) @(negedge w_clk);
      repeat (2) @(negedge r_clk);
      checks += 7;
      if (s_write_tready !== 1'b0) begin failures++; $display("FAIL reset_wready got=%b expected=0", s_write_tready); end
      if (s_write_count !== '0) begin failures++; $display("FAIL reset_wcount got=%0d expected=0", s_write_count); end
      if (s_write_afull !== 1'b0) begin failures++; $display("FAIL reset_afull got=%b expected=0", s_write_afull); end
      if (s_read_tvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b expected=0", s_read_tvalid); end
      if (s_read_count !== '0) begin failures++; $display("FAIL reset_rcount got=%0d expected=0", s_read_count); end
      if (s_read_aempty !== 1'b1) begin failures++; $display("FAIL reset_aempty got=%b expected=1", s_read_aempty); end
      if (p_read_tvalid !== 1'b0) begin failures++; $display("FAIL reset_p_rvalid got=%b expected=0", p_read_tvalid); end
      write_tvalid = 0;
      w_reset = 0; r_reset = 0;
      sb_q.delete(); committed = 0;
      repeat (3) @(negedge w_clk);
      repeat (6) @(negedge r_clk);
      checks += 2;
      if (s_write_tready !== 1'b1) begin failures++; $display("FAIL post_reset_wready got=%b expected=1", s_write_tready); end
      if (s_read_tvalid !== 1'b0) begin failures++; $display("FAIL post_reset_rvalid got=%b expected=0", s_read_tvalid); end
   endtask

   task automatic test_stream();
      fork
         drive_writes(11000, 0);
         consume_reads(11000, 0, 60);
      join
   endtask

   task automatic test_fill();
      bit leak = 0;
      read_tready = 0;
      push_beats(4, 0, 0);
      checks += 3;
      if (s_write_tready !== 1'b0) begin failures++; $display("FAIL fill_wready got=%b expected=0", s_write_tready); end
      if (s_write_count !== 3'd4) begin failures++; $display("FAIL fill_wcount got=%0d expected=4", s_write_count); end
      if (s_write_afull !== 1'b1) begin failures++; $display("FAIL fill_afull got=%b expected=1", s_write_afull); end
      write_tvalid = 1; write_data = rand_data(); write_tlast = 1;
      repeat (10) begin
         @(negedge w_clk);
         if (s_write_tready !== 1'b0) leak = 1;
      end
      write_tvalid = 0;
      repeat (2) @(negedge r_clk);
      checks += 5;
      if (leak) begin failures++; $display("FAIL fill_hold_wready got=1 expected=0"); end
      if (s_write_count !== 3'd4) begin failures++; $display("FAIL fill_wcount_hold got=%0d expected=4", s_write_count); end
      if (s_read_count !== 3'd4) begin failures++; $display("FAIL fill_rcount got=%0d expected=4", s_read_count); end
      if (s_read_aempty !== 1'b0) begin failures++; $display("FAIL fill_aempty got=%b expected=0", s_read_aempty); end
      if (s_read_tvalid !== 1'b1) begin failures++; $display("FAIL fill_rvalid got=%b expected=1", s_read_tvalid); end
   endtask

   task automatic test_drain();
      int got = 0, k = 0;
      logic [DW:0] exp;
      fork
         begin
            @(negedge r_clk);
            read_tready = 1;
            repeat (30) begin
               if (s_read_tvalid) begin
                  got++;
                  if (sb_q.size() > 0) begin
                     exp = sb_q.pop_front();
                     checks++;
                     if ({s_read_tlast, s_read_data} !== exp) begin
                        failures++;
                        $display("FAIL drain_data got=%h expected=%h", {s_read_tlast, s_read_data}, exp);
                     end
                  end
               end
               @(negedge r_clk);
            end
            read_tready = 0;
            checks += 4;
            if (got != 4) begin failures++; $display("FAIL drain_beats got=%0d expected=4", got); end
            if (s_read_tvalid !== 1'b0) begin failures++; $display("FAIL drain_rvalid got=%b expected=0", s_read_tvalid); end
            if (s_read_count !== '0) begin failures++; $display("FAIL drain_rcount got=%0d expected=0", s_read_count); end
            if (s_read_aempty !== 1'b1) begin failures++; $display("FAIL drain_aempty got=%b expected=1", s_read_aempty); end
         end
         begin
            @(posedge read_tready);
            do begin
               @(negedge w_clk); k++;
            end while (!s_write_tready && k < SS + 3);
            checks++;
            if (!s_write_tready || k > SS + 2) begin
               failures++;
               $display("FAIL drain_wready_latency got=%0d cycles (ready=%b) expected<=%0d", k, s_write_tready, SS + 2);
            end
         end
      join
      committed = sb_q.size();
   endtask

   task automatic test_packet();
      bit seen = 0;
      int got = 0, guard = 0;
      logic [DW:0] exp;
      read_tready = 1;
      push_beats(2, 1, 0);
      repeat (20) begin
         @(negedge r_clk);
         if (p_read_tvalid) seen = 1;
      end
      checks++;
      if (seen) begin failures++; $display("FAIL pkt_uncommitted_visible got=1 expected=0"); end
      push_beats(1, 1, 1);
      while (got < 3 && guard < 40) begin
         @(negedge r_clk); guard++;
         if (p_read_tvalid) begin
            exp = sb_q.pop_front(); committed--;
            checks++;
            if ({p_read_tlast, p_read_data} !== exp || p_read_tlast !== (got == 2)) begin
               failures++;
               $display("FAIL pkt_beat%0d got=%h expected=%h", got, {p_read_tlast, p_read_data}, exp);
            end
            got++;
         end
      end
      read_tready = 0;
      checks++;
      if (got != 3) begin failures++; $display("FAIL pkt_beats got=%0d expected=3", got); end
   endtask

   task automatic test_packet_deadlock();
      bit moved = 0;
      read_tready = 1;
      push_beats(4, 1, 0);
      write_tvalid = 1; write_data = rand_data(); write_tlast = 1;
      repeat (20) begin
         @(negedge w_clk);
         if (p_write_tready || p_read_tvalid) moved = 1;
      end
      checks += 3;
      if (moved) begin failures++; $display("FAIL deadlock_progress got=1 expected=0"); end
      if (p_write_count !== 3'd4) begin failures++; $display("FAIL deadlock_wcount got=%0d expected=4", p_write_count); end
      if (p_write_afull !== 1'b1) begin failures++; $display("FAIL deadlock_afull got=%b expected=1", p_write_afull); end
      write_tvalid = 0; read_tready = 0;
   endtask

   task automatic test_packet_stream();
      fork
         drive_writes(5000, 1);
         consume_reads(5000, 1, 80);
      join
   endtask

   task automatic test_reset_midstream();
      bit bad = 0;
      read_tready = 0;
      push_beats(2, 0, 0);
      repeat (SS + 3) @(negedge r_clk);
      checks++;
      if (s_read_count !== 3'd2) begin failures++; $display("FAIL mid_buffered got=%0d expected=2", s_read_count); end
      w_reset = 1; r_reset = 1;
      sb_q.delete(); committed = 0;
      repeat (6) begin
         @(negedge r_clk);
         if (s_write_tready !== 1'b0 || s_read_tvalid !== 1'b0) bad = 1;
      end
      checks++;
      if (bad) begin failures++; $display("FAIL mid_reset_handshake got=active expected=both low"); end
      w_reset = 0; r_reset = 0;
      repeat (2) @(negedge w_clk);
      repeat (2) @(negedge r_clk);
      checks += 4;
      if (s_write_count !== '0) begin failures++; $display("FAIL mid_wcount got=%0d expected=0", s_write_count); end
      if (s_read_count !== '0) begin failures++; $display("FAIL mid_rcount got=%0d expected=0", s_read_count); end
      if (s_read_tvalid !== 1'b0) begin failures++; $display("FAIL mid_rvalid got=%b expected=0", s_read_tvalid); end
      if (s_write_tready !== 1'b1) begin failures++; $display("FAIL mid_wready got=%b expected=1", s_write_tready); end
      fork
         drive_writes(100, 0);
         consume_reads(100, 0, 70);
      join
   endtask

   initial begin
      #20ms;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_stream();
      do_reset();
      test_fill();
      test_drain();
      do_reset();
      test_packet();
      do_reset();
      test_packet_deadlock();
      w_half = 5; r_half = 10;
      do_reset();
      test_packet_stream();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
